u_binary_multiplier: RTL and testbench
======================================

Name: u_binary_multiplier

Overview:
- Sequential unsigned shift-and-add multiplier with a start/done handshake.
- Multiplies two WIDTH-bit operands into a 2*WIDTH-bit product, processing one multiplier bit per clock.
- Small arithmetic leaf block for FPGA demo datapaths where area matters more than latency.

Parameters:
- WIDTH, 3, operand width in bits; product is 2*WIDTH bits; legal range 2..16.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- inA  input  WIDTH  multiplicand, unsigned; sampled only when the operation starts.
- inB  input  WIDTH  multiplier, unsigned; sampled only when the operation starts.
- start  input  1  level request; sampled on the rising edge while in IDLE.
- product  output  2*WIDTH  registered result; valid whenever done=1.
- done  output  1  registered completion flag.

Behaviour:
- Reset, synchronous and active-high on the clk rising edge, has priority over everything else:
  - state goes to IDLE;
  - product=0, done=0;
  - internal accumulator, operand registers and bit counter are cleared.
- Reset asserted mid-operation aborts the operation; no partial result is ever exposed.
- States: IDLE, CALC, DONE.
- IDLE:
  - done=0; product holds the last completed result (0 after reset).
  - On an edge with start=1: load A=inA (zero-extended to 2*WIDTH), B=inB, acc=0, count=WIDTH, and go to CALC. This is edge e0.
- CALC, each edge e1..eWIDTH:
  - if B[0]=1 then acc=acc+A (2*WIDTH-bit add, no overflow possible);
  - then A shifts left 1, B shifts right 1, count decrements.
  - On the edge where count reaches 0: product takes the final acc value, done=1, state goes to DONE.
- Latency: done and product are valid after edge e(WIDTH), i.e. WIDTH+1 rising edges after start is first sampled. For WIDTH=3 that is 4 edges.
- In CALC, start and inA/inB are ignored; changing operands mid-operation has no effect.
- DONE:
  - done=1 and product stable.
  - Remain in DONE while start=1.
  - On an edge with start=0: done=0, go to IDLE. Product keeps its value.
- A new operation therefore requires start to be low for at least one edge (DONE to IDLE), then high again.
- start held continuously high does not retrigger.
- Boundary cases:
  - Either operand 0 gives product 0 with normal latency.
  - Maximum operands (2^WIDTH-1) squared fit in 2*WIDTH bits; for WIDTH=3, 7*7=49.
  - Reset asserted on the same edge that would complete the operation wins: product=0, done=0.

Optional Feature:
- Macro EARLY_TERM_EN.
- When defined: in CALC, if the shifted multiplier register B becomes 0 after processing the current bit, the block finishes on that edge (product updated, done=1, go to DONE) without processing the remaining bits.
  - Minimum latency is 2 edges (e0 plus one CALC edge), e.g. inB=0 or inB=1.
  - Maximum latency is WIDTH+1 edges.
  - Results are identical to the non-early-termination build.
- When undefined: fixed latency of WIDTH+1 edges regardless of operand values.

Test Plan:
- Reset, inA=2, inB=3, raise and hold start -> done=1 after 4 edges, product=6; done stays 1 while start=1.
- Separate runs, each with reset then start: 6*5 -> 30; 3*7 -> 21; 4*5 -> 20; 7*7 -> 49; 2*4 -> 8. Each run has done=0 until exactly edge e3 and product held thereafter.
- inA=0, inB=7 and inA=5, inB=0 -> product=0.
  - Without EARLY_TERM_EN, done after 4 edges.
  - With EARLY_TERM_EN, inB=0 completes after 2 edges; 7*1 completes after 2 edges with product 7.
- Assert reset during CALC (after e1 of 6*5) -> next edge product=0, done=0, state IDLE; a restarted 6*5 then yields 30 with full latency.
- After done, change inA/inB with start still high -> no retrigger, product unchanged. Drop start -> done=0 next edge, product retained. Raise start again -> new result with normal latency.
- Change inA/inB during CALC -> result reflects the operands sampled at e0.

Source files
------------

// File: rtl/u_binary_multiplier.sv
// u_binary_multiplier: sequential shift-and-add unsigned multiplier with start/done handshake; define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero
module u_binary_multiplier #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  input  logic               start,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   a_q, a_d, acc_q, acc_d, product_q, product_d, sum;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d, last;
  assign product = product_q;
  assign done    = done_q;
  // next-state and datapath: load on start, one multiplier bit per CALC edge, hold result in DONE
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = done_q;
    sum       = b_q[0] ? acc_q + a_q : acc_q;
`ifdef EARLY_TERM_EN
    last      = (cnt_q == CW'(1)) || ((b_q >> 1) == '0);
`else
    last      = cnt_q == CW'(1);
`endif
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          a_d     = {{WIDTH{1'b0}}, inA};
          b_d     = inB;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          product_d = sum;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset clears everything so an aborted operation never leaks a partial result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_u_binary_multiplier.sv
// tb_u_binary_multiplier: vector table, corner sequences and random operations against an arithmetic model
module tb_u_binary_multiplier;
  localparam int W = 3;
  logic           clk = 0, reset = 1, start = 0;
  logic [W-1:0]   inA = 0, inB = 0;
  logic [2*W-1:0] product;
  logic           done;
  int tests = 0, fails = 0;

  u_binary_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .inA(inA), .inB(inB),
    .start(start), .product(product), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int p;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input int b);
`ifdef EARLY_TERM_EN
    int n = 0;
    while (b != 0) begin
      n++;
      b = b >> 1;
    end
    return (n < 1 ? 1 : n) + 1;
`else
    return W + 1;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    start = 0;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic start_op(input int a, input int b);
    @(negedge clk);
    inA   = W'(a);
    inB   = W'(b);
    start = 1;
  endtask

  task automatic wait_done(input string nm, input int a, input int b);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        inA = W'($urandom_range(0, 7));
        inB = W'($urandom_range(0, 7));
      end
    end while (!done && n < 40);
    chk({nm, " latency"}, n, exp_lat(b));
    chk({nm, " product"}, product, a * b);
  endtask

  task automatic end_op(input string nm, input int p);
    repeat (2) @(negedge clk);
    chk({nm, " done held"}, done, 1);
    chk({nm, " product held"}, product, p);
    start = 0;
    @(negedge clk);
    chk({nm, " done drop"}, done, 0);
    chk({nm, " product kept"}, product, p);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2, 3, 6};
    vecs[1] = '{6, 5, 30};
    vecs[2] = '{3, 7, 21};
    vecs[3] = '{4, 5, 20};
    vecs[4] = '{7, 7, 49};
    vecs[5] = '{2, 4, 8};
    vecs[6] = '{0, 7, 0};
    vecs[7] = '{5, 0, 0};
    vecs[8] = '{7, 1, 7};

    do_reset();
    chk("reset product", product, 0);
    chk("reset done", done, 0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      chk("pre-start done", done, 0);
      start_op(vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d table", i), product, vecs[i].p);
      end_op($sformatf("vec%0d", i), vecs[i].p);
    end

    start_op(6, 5);
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    start = 0;
    @(negedge clk);
    reset = 0;
    chk("abort product", product, 0);
    chk("abort done", done, 0);
    @(negedge clk);
    chk("abort idle done", done, 0);
    start_op(6, 5);
    wait_done("restart", 6, 5);
    end_op("restart", 30);

    start_op(7, 7);
    repeat (exp_lat(7) - 1) @(negedge clk);
    reset = 1;
    start = 0;
    @(negedge clk);
    reset = 0;
    chk("reset on finish product", product, 0);
    chk("reset on finish done", done, 0);

    start_op(3, 5);
    wait_done("noretrig", 3, 5);
    inA = 7;
    inB = 7;
    repeat (6) @(negedge clk);
    chk("noretrig done", done, 1);
    chk("noretrig product", product, 15);
    start = 0;
    @(negedge clk);
    chk("noretrig drop", done, 0);
    chk("noretrig kept", product, 15);
    start_op(7, 6);
    wait_done("retrig", 7, 6);
    end_op("retrig", 42);

    for (int i = 0; i < 20; i++) begin
      int a, b;
      a = int'($urandom_range(0, 7));
      b = int'($urandom_range(0, 7));
      start_op(a, b);
      wait_done($sformatf("rand%0d", i), a, b);
      end_op($sformatf("rand%0d", i), a * b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
